alu_shift_regfile_seq: RTL
==========================

Name: alu_shift_regfile_seq

Overview:
Parametrised successor to the single-cycle ALU/shifter/register datapath. It accepts one command per valid/ready handshake and computes ALU(A, M), where M comes from the B input or an internal register file. It then applies a multi-cycle shifter at one bit per cycle and returns the result with carry and zero flags on a valid/ready output. On result handshake it optionally writes the result back into the register file.

Parameters:
WIDTH, 9, datapath width in bits (>=2)
NREGS, 4, number of internal registers (>=1)
RW, $clog2(NREGS) min 1, register index width (derived localparam)
SHW, $clog2(WIDTH+1), shift-amount width (derived localparam)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  3  ALU operation
cmd_src_sel  input  1  0: M = b_in; 1: M = regfile[cmd_rsrc]
cmd_rsrc  input  RW  source register index
cmd_shmode  input  2  shift mode
cmd_shamt  input  SHW  shift amount
cmd_wr_en  input  1  write result back on completion
cmd_rdst  input  RW  destination register index
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  result
res_carry  output  1  carry/shift-out flag
res_zero  output  1  res_data == 0
busy  output  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all registers, work register, count, and flags = 0; res_valid=0; cmd_ready=1 after release. An in-flight command is dropped and no write-back occurs.
- FSM states: IDLE, SHIFT, DONE. cmd_ready = (state==IDLE).
- IDLE + cmd_valid:
  - Latch the ALU result into work and the ALU carry; latch shmode, shamt, wr_en, rdst; count = shamt.
  - If shmode==00 or shamt==0: go to DONE. Otherwise go to SHIFT.
- ALU ops:
  - 000 A
  - 001 A+M, carry = bit WIDTH of the sum
  - 010 A-M computed as A+~M+1, carry = 1 when no borrow (A>=M unsigned)
  - 011 A&M
  - 100 A|M
  - 101 A^M
  - 110 ~A
  - 111 M
  - Logic ops and passes give carry=0. Arithmetic wraps modulo 2^WIDTH.
- SHIFT, one bit per cycle:
  - 01 logical left: carry = msb out, fill 0.
  - 10 logical right: carry = lsb out, fill 0.
  - 11 arithmetic right: carry = lsb out, fill msb.
  - count decrements each cycle. The cycle that shifts with count==1 moves to DONE.
  - shamt>=WIDTH is legal: left/logical right give 0; arithmetic right gives all sign bits.
- Latency: res_valid asserts 1 cycle after the accept edge, or 1+shamt cycles when shifting. No command overlap: throughput is one per 2+shamt cycles minimum.
- DONE: res_valid=1.
  - res_data, res_carry, and res_zero are stable while res_valid=1 and res_ready=0.
  - On res_valid&&res_ready: if wr_en, regfile[rdst] = work. Go to IDLE.
  - A command accepted the following cycle sees the written value.
- Register index >= NREGS (non-power-of-two NREGS): reads return 0; writes are ignored.
- cmd_rsrc == previous rdst: reads the updated value, because the write occurs before cmd_ready rises.
- Inputs a_in, b_in, and cmd_* are only sampled on the accept edge and are don't-care otherwise.

Decomposition:
- Package alu_seq_pkg:
  - ALU op codes: OP_PASSA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOTA, OP_PASSM.
  - Shift mode codes: SH_NONE, SH_LSL, SH_LSR, SH_ASR.
  - State enum: IDLE/SHIFT/DONE.
- One sub-module, alu_core: combinational, parameter WIDTH; inputs a, m, op; outputs x, carry.
- Register file, shifter step, and FSM stay in the top block.

Test Plan:
- Reset, then cmd op=001, src_sel=0, A=8, B=5, shmode=00 -> res_valid exactly 1 cycle after accept; res_data=13, carry=0, zero=0.
- op=010, A=5, B=8, no shift -> res_data=509 (9-bit wrap), carry=0. Then A=8, B=8 -> res_data=0, zero=1, carry=1.
- op=000, A=13, shmode=01, shamt=3 -> res_valid 4 cycles after accept; res_data=104, carry=0. Then shmode=11, A=256, shamt=2 -> res_data=448, carry=0.
- Write-back chain:
  - Step 1: op=001, A=8, B=5, wr_en=1, rdst=2.
  - Step 2: op=001, A=1, src_sel=1, rsrc=2 -> res_data=14.
  - Step 3: rsrc=3 (never written) -> res_data=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid and res_data stable, cmd_ready=0, cmd_valid ignored. On release, the handshake completes and cmd_ready=1 the next cycle.
- Async rst pulse mid-SHIFT (shamt=8, 3 cycles in) with wr_en=1 -> outputs zero immediately, no register write (a later read of rdst returns 0), next command processes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared op codes, shift modes and FSM states for the sequential ALU/shifter
//
// Purpose: common types for alu_core and alu_shift_regfile_seq.
//   alu_op_e  : 3-bit ALU operation encoding
//   sh_mode_e : 2-bit shift mode encoding
//   state_e   : control FSM states
//   idx_width : register index width, never less than 1 bit
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_PASSA = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_OR    = 3'b100,
        OP_XOR   = 3'b101,
        OP_NOTA  = 3'b110,
        OP_PASSM = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } sh_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // A single register still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU producing result and carry
//
// Purpose: computes x = op(a, m) with carry for add/sub, 0 otherwise.
// Ports:
//   a     in  WIDTH  operand A
//   m     in  WIDTH  operand M (B input or register file value)
//   op    in  3      operation, alu_op_e encoding
//   x     out WIDTH  result, arithmetic wraps modulo 2^WIDTH
//   carry out 1      add: carry out; sub: 1 when no borrow (a >= m)
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] x,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, m};
    // a + ~m + 1: the top bit is set exactly when no borrow occurs.
    assign diff = {1'b0, a} + {1'b0, ~m} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        x     = '0;
        carry = 1'b0;
        case (alu_op_e'(op))
            OP_PASSA: x = a;
            OP_ADD: begin
                x     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                x     = diff[WIDTH-1:0];
                carry = diff[WIDTH];
            end
            OP_AND:   x = a & m;
            OP_OR:    x = a | m;
            OP_XOR:   x = a ^ m;
            OP_NOTA:  x = ~a;
            OP_PASSM: x = m;
            default:  x = '0;
        endcase
    end

endmodule

// File: rtl/alu_shift_regfile_seq.sv
// rtl/alu_shift_regfile_seq.sv - handshaked ALU, bit-serial shifter and register file with write-back
//
// Purpose: accepts one command per cmd handshake, computes ALU(A, M) where M
// is b_in or a register, shifts the result one bit per cycle, and presents
// result/carry/zero on a res handshake; optionally writes the result back.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready  command handshake; ready only in IDLE
//   cmd_op           ALU operation (alu_op_e)
//   cmd_src_sel      0: M = b_in, 1: M = regfile[cmd_rsrc]
//   cmd_rsrc         source register index
//   cmd_shmode       shift mode (sh_mode_e)
//   cmd_shamt        shift amount, values >= WIDTH are legal
//   cmd_wr_en        write result to regfile[cmd_rdst] on result handshake
//   cmd_rdst         destination register index
//   a_in, b_in       operands, sampled only on the accept edge
//   res_valid/ready  result handshake
//   res_data         result
//   res_carry        ALU carry, or last bit shifted out
//   res_zero         result is zero (only while res_valid)
//   busy             FSM not idle
module alu_shift_regfile_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int NREGS = 4,
    localparam int RW  = idx_width(NREGS),
    localparam int SHW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_src_sel,
    input  logic [RW-1:0]    cmd_rsrc,
    input  logic [1:0]       cmd_shmode,
    input  logic [SHW-1:0]   cmd_shamt,
    input  logic             cmd_wr_en,
    input  logic [RW-1:0]    cmd_rdst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             busy
);

    state_e           state;
    state_e           state_nxt;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] work;
    logic             carry_q;
    logic [1:0]       shmode_q;
    logic [SHW-1:0]   count;
    logic             wr_en_q;
    logic [RW-1:0]    rdst_q;

    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] m_val;
    logic [WIDTH-1:0] alu_x;
    logic             alu_carry;
    logic [WIDTH-1:0] shift_work;
    logic             shift_carry;
    logic             accept;
    logic             res_fire;

    assign accept   = cmd_valid && (state == IDLE);
    assign res_fire = (state == DONE) && res_ready;

    // Indices with no backing register (non-power-of-two NREGS) read as 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (cmd_rsrc == i[RW-1:0]) begin
                rd_val = regs[i];
            end
        end
    end

    assign m_val = cmd_src_sel ? rd_val : b_in;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a     (a_in),
        .m     (m_val),
        .op    (cmd_op),
        .x     (alu_x),
        .carry (alu_carry)
    );

    // One-bit shift step; carry always takes the bit that falls off.
    always_comb begin
        shift_work  = work;
        shift_carry = carry_q;
        case (sh_mode_e'(shmode_q))
            SH_LSL: begin
                shift_carry = work[WIDTH-1];
                shift_work  = {work[WIDTH-2:0], 1'b0};
            end
            SH_LSR: begin
                shift_carry = work[0];
                shift_work  = {1'b0, work[WIDTH-1:1]};
            end
            SH_ASR: begin
                shift_carry = work[0];
                shift_work  = {work[WIDTH-1], work[WIDTH-1:1]};
            end
            default: begin
                shift_work  = work;
                shift_carry = carry_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_shmode == SH_NONE) || (cmd_shamt == '0)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (count == SHW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work     <= '0;
            carry_q  <= 1'b0;
            shmode_q <= 2'b00;
            count    <= '0;
            wr_en_q  <= 1'b0;
            rdst_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (accept) begin
                work     <= alu_x;
                carry_q  <= alu_carry;
                shmode_q <= cmd_shmode;
                count    <= cmd_shamt;
                wr_en_q  <= cmd_wr_en;
                rdst_q   <= cmd_rdst;
            end else if (state == SHIFT) begin
                work    <= shift_work;
                carry_q <= shift_carry;
                count   <= count - 1'b1;
            end
            // Write-back lands on the handshake edge, so the command accepted
            // in the following IDLE cycle already reads the new value.
            if (res_fire && wr_en_q) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (rdst_q == i[RW-1:0]) begin
                        regs[i] <= work;
                    end
                end
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);
    assign res_data  = work;
    assign res_carry = carry_q;
    assign res_zero  = (state == DONE) && (work == '0);

endmodule
